// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the RV64 load/store unit: funct3 encodings,
// FSM state encoding and the access-width helpers.
package risc_v_mem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_SD  = 3'b011;

  // Plain vector encoding keeps the state register readable by older tools.
  typedef logic [2:0] lsu_state_t;
  localparam lsu_state_t S_IDLE     = 3'd0;
  localparam lsu_state_t S_LOAD     = 3'd1;
  localparam lsu_state_t S_ST_READ  = 3'd2;
  localparam lsu_state_t S_ST_WRITE = 3'd3;
  localparam lsu_state_t S_RESP     = 3'd4;

  // Number of bytes touched by an access; the unsigned variants share the
  // width bits with their signed counterparts.
  function automatic logic [3:0] access_bytes(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   access_bytes = 4'd1;
      2'b01:   access_bytes = 4'd2;
      2'b10:   access_bytes = 4'd4;
      default: access_bytes = 4'd8;
    endcase
  endfunction

  // Mask covering the least-significant bytes of the window for this access.
  function automatic logic [63:0] byte_mask(input logic [2:0] funct3);
    logic [3:0] n;
    byte_mask = '0;
    n = access_bytes(funct3);
    for (int i = 0; i < 8; i++) begin
      if (i < int'(n)) byte_mask[8*i +: 8] = 8'hFF;
    end
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response bus between the datapath (master) and the load/store
// unit (slave).
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [63:0] resp_rdata;

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_err, resp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata,
    output req_ready, resp_valid, resp_err, resp_rdata
  );
endinterface

// File: rtl/load_store_unit_extend.sv
// Combinational load formatter: picks the low bytes of a memory window
// and sign- or zero-extends them according to funct3.
module mem_load_extend
  import risc_v_mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [63:0] window,
  output logic [63:0] result
);

  // Select width and extension kind for the loaded value.
  always_comb begin
    result = '0;
    case (funct3)
      F3_LB:   result = {{56{window[7]}},  window[7:0]};
      F3_LH:   result = {{48{window[15]}}, window[15:0]};
      F3_LW:   result = {{32{window[31]}}, window[31:0]};
      F3_LD:   result = window;
      F3_LBU:  result = {56'd0, window[7:0]};
      F3_LHU:  result = {48'd0, window[15:0]};
      F3_LWU:  result = {32'd0, window[31:0]};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV64 load/store unit. Memory only moves whole 8-byte windows, so
// narrow stores read the window, merge the new low bytes and write it back.
module load_store_unit
  import risc_v_mem_pkg::*;
#(
  parameter int MEM_BYTES = 2048
) (
  input  logic                clk,
  input  logic                reset_n,
  load_store_unit_if.slave    bus,
  output logic                mem_read,
  output logic                mem_write,
  output logic [63:0]         mem_addr,
  output logic [63:0]         mem_write_data,
  input  logic [63:0]         mem_read_data
);

  localparam logic [63:0] LAST_WINDOW = 64'(MEM_BYTES - 8);

  lsu_state_t  state;
  lsu_state_t  state_next;
  logic [63:0] addr_q;
  logic [2:0]  funct3_q;
  logic [63:0] wdata_q;
  logic [63:0] merge_q;
  logic [63:0] rdata_q;
  logic        err_q;

  logic        accept;
  logic        req_bad;
  logic [63:0] load_result;
  logic [63:0] store_data;
  logic [63:0] store_mask;

  assign accept  = bus.req_valid && (state == S_IDLE);
  assign req_bad = (bus.req_write ? bus.req_funct3[2] : (bus.req_funct3 == 3'b111))
                   || (bus.req_addr > LAST_WINDOW);

  mem_load_extend u_extend (
    .funct3 (funct3_q),
    .window (mem_read_data),
    .result (load_result)
  );

  assign store_mask = byte_mask(funct3_q);
  assign store_data = (funct3_q == F3_SD) ? wdata_q
                      : ((merge_q & ~store_mask) | (wdata_q & store_mask));

  // Next-state decode; errors skip memory entirely, SD skips the read.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (bus.req_valid) begin
          if (req_bad)                       state_next = S_RESP;
          else if (!bus.req_write)           state_next = S_LOAD;
          else if (bus.req_funct3 == F3_SD)  state_next = S_ST_WRITE;
          else                               state_next = S_ST_READ;
        end
      end
      S_LOAD:     state_next = S_RESP;
      S_ST_READ:  state_next = S_ST_WRITE;
      S_ST_WRITE: state_next = S_RESP;
      S_RESP:     state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
  end

  // State, captured request fields, merge window and load result registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      addr_q   <= '0;
      funct3_q <= '0;
      wdata_q  <= '0;
      merge_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        addr_q   <= bus.req_addr;
        funct3_q <= bus.req_funct3;
        wdata_q  <= bus.req_wdata;
        err_q    <= req_bad;
      end
      if (state == S_LOAD)    rdata_q <= load_result;
      if (state == S_ST_READ) merge_q <= mem_read_data;
    end
  end

  assign bus.req_ready  = (state == S_IDLE);
  assign bus.resp_valid = (state == S_RESP);
  assign bus.resp_err   = (state == S_RESP) && err_q;
  assign bus.resp_rdata = rdata_q;

  // Memory strobes come straight from state so reset cancels a write at once.
  assign mem_read       = (state == S_LOAD) || (state == S_ST_READ);
  assign mem_write      = (state == S_ST_WRITE);
  assign mem_addr       = (mem_read || mem_write) ? addr_q : '0;
  assign mem_write_data = mem_write ? store_data : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a byte-array memory model.
module tb_load_store_unit;
  import risc_v_mem_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        mem_read;
  logic        mem_write;
  logic [63:0] mem_addr;
  logic [63:0] mem_write_data;
  logic [63:0] mem_read_data;

  logic [7:0]  mem [0:2047];

  int          vectors;
  int          miscompares;

  int          tr_lat;
  int          tr_rd;
  int          tr_wr;
  int          tr_rd_first;
  int          tr_wr_first;
  logic        tr_err;
  logic        tr_ready;
  logic [63:0] tr_rdata;

  load_store_unit_if bus ();

  load_store_unit #(.MEM_BYTES(2048)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .bus            (bus),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational window read, M[a] in the most significant byte.
  always_comb begin
    mem_read_data = '0;
    if (mem_addr <= 64'd2040) begin
      for (int i = 0; i < 8; i++)
        mem_read_data[63-8*i -: 8] = mem[mem_addr[10:0] + 11'(i)];
    end
  end

  // Whole-window write on the clock edge.
  always @(posedge clk) begin
    if (mem_write && mem_addr <= 64'd2040) begin
      for (int i = 0; i < 8; i++)
        mem[mem_addr[10:0] + 11'(i)] = mem_write_data[63-8*i -: 8];
    end
  end

  // Hard stop in case the sequence itself stalls.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [63:0] peek_window(input int a);
    logic [63:0] w;
    for (int i = 0; i < 8; i++) w[63-8*i -: 8] = mem[11'(a + i)];
    return w;
  endfunction

  task automatic load_window(input int a, input logic [63:0] pat);
    for (int i = 0; i < 8; i++) mem[11'(a + i)] = pat[63-8*i -: 8];
  endtask

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $display("[TB] FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
      $error("[TB] %s miscompared", tag);
    end
  endtask

  // One request: accept, scramble request fields, wait for resp_valid (bounded),
  // recording latency and memory strobe activity; returns with the unit idle.
  task automatic apply_stimulus(input logic w, input logic [2:0] f3,
                                input logic [63:0] a, input logic [63:0] d);
    logic got;
    bus.req_valid  = 1'b1;
    bus.req_write  = w;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = d;
    tr_ready = bus.req_ready;
    @(posedge clk); #1;
    bus.req_valid  = 1'b0;
    bus.req_funct3 = 3'b111;
    bus.req_addr   = 64'h0000_0000_0000_0010;
    bus.req_wdata  = 64'hFFFF_FFFF_FFFF_FFFF;
    got = 1'b0;
    tr_lat = 1; tr_rd = 0; tr_wr = 0; tr_rd_first = 0; tr_wr_first = 0;
    tr_err = 1'bx; tr_rdata = 'x;
    while (!got && tr_lat <= 8) begin
      if (bus.resp_valid) begin
        got      = 1'b1;
        tr_err   = bus.resp_err;
        tr_rdata = bus.resp_rdata;
      end else begin
        if (mem_read) begin
          tr_rd++;
          if (tr_rd_first == 0) tr_rd_first = tr_lat;
        end
        if (mem_write) begin
          tr_wr++;
          if (tr_wr_first == 0) tr_wr_first = tr_lat;
        end
        tr_lat++;
        @(posedge clk); #1;
      end
    end
    if (!got) tr_lat = 99;
    @(posedge clk); #1;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset_n = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    for (int i = 0; i < 2048; i++) mem[i] = 8'hEE;
    load_window(32, 64'h8040_2010_0804_0201);
    load_window(40, 64'h80C0_A090_8884_8281);

    repeat (2) @(posedge clk);
    #1;
    check_output("rst_req_ready",  64'(bus.req_ready), 64'd1);
    check_output("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    check_output("rst_resp_err",   64'(bus.resp_err), 64'd0);
    check_output("rst_resp_rdata", bus.resp_rdata, 64'd0);
    check_output("rst_mem_read",   64'(mem_read), 64'd0);
    check_output("rst_mem_write",  64'(mem_write), 64'd0);
    check_output("rst_mem_addr",   mem_addr, 64'd0);
    check_output("rst_mem_wdata",  mem_write_data, 64'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Loads at 32
    apply_stimulus(1'b0, F3_LB, 64'd32, 64'd0);
    check_output("lb32_ready", 64'(tr_ready), 64'd1);
    check_output("lb32_data", tr_rdata, 64'd1);
    check_output("lb32_lat", 64'(tr_lat), 64'd2);
    check_output("lb32_err", 64'(tr_err), 64'd0);
    check_output("lb32_rd", 64'(tr_rd), 64'd1);
    check_output("lb32_wr", 64'(tr_wr), 64'd0);
    apply_stimulus(1'b0, F3_LH, 64'd32, 64'd0);
    check_output("lh32_data", tr_rdata, 64'd513);
    check_output("lh32_lat", 64'(tr_lat), 64'd2);
    apply_stimulus(1'b0, F3_LW, 64'd32, 64'd0);
    check_output("lw32_data", tr_rdata, 64'd134480385);
    check_output("lw32_lat", 64'(tr_lat), 64'd2);
    apply_stimulus(1'b0, F3_LD, 64'd32, 64'd0);
    check_output("ld32_data", tr_rdata, 64'h8040_2010_0804_0201);
    check_output("ld32_lat", 64'(tr_lat), 64'd2);

    // Loads at 40, sign vs zero extension
    apply_stimulus(1'b0, F3_LB, 64'd40, 64'd0);
    check_output("lb40_data", tr_rdata, 64'hFFFF_FFFF_FFFF_FF81);
    apply_stimulus(1'b0, F3_LBU, 64'd40, 64'd0);
    check_output("lbu40_data", tr_rdata, 64'd129);
    apply_stimulus(1'b0, F3_LH, 64'd40, 64'd0);
    check_output("lh40_data", tr_rdata, 64'hFFFF_FFFF_FFFF_8281);
    apply_stimulus(1'b0, F3_LHU, 64'd40, 64'd0);
    check_output("lhu40_data", tr_rdata, 64'd33409);
    apply_stimulus(1'b0, F3_LW, 64'd40, 64'd0);
    check_output("lw40_data", tr_rdata, 64'hFFFF_FFFF_8884_8281);
    apply_stimulus(1'b0, F3_LWU, 64'd40, 64'd0);
    check_output("lwu40_data", tr_rdata, 64'd2290385537);

    // SB read-modify-write
    apply_stimulus(1'b1, F3_SB, 64'd40, 64'h1234_5678_9ABC_DEAB);
    check_output("sb_lat", 64'(tr_lat), 64'd3);
    check_output("sb_err", 64'(tr_err), 64'd0);
    check_output("sb_rd", 64'(tr_rd), 64'd1);
    check_output("sb_wr", 64'(tr_wr), 64'd1);
    check_output("sb_rd_cycle", 64'(tr_rd_first), 64'd1);
    check_output("sb_wr_cycle", 64'(tr_wr_first), 64'd2);
    check_output("sb_rdata_kept", tr_rdata, 64'd2290385537);
    apply_stimulus(1'b0, F3_LD, 64'd40, 64'd0);
    check_output("sb_readback", tr_rdata, 64'h80C0_A090_8884_82AB);

    // SH and SW merges
    apply_stimulus(1'b1, F3_SH, 64'd32, 64'hFFFF_FFFF_FFFF_BEEF);
    check_output("sh_lat", 64'(tr_lat), 64'd3);
    apply_stimulus(1'b0, F3_LD, 64'd32, 64'd0);
    check_output("sh_readback", tr_rdata, 64'h8040_2010_0804_BEEF);
    apply_stimulus(1'b1, F3_SW, 64'd40, 64'hDEAD_BEEF_1122_3344);
    check_output("sw_lat", 64'(tr_lat), 64'd3);
    apply_stimulus(1'b0, F3_LD, 64'd40, 64'd0);
    check_output("sw_readback", tr_rdata, 64'h80C0_A090_1122_3344);

    // SD writes directly
    apply_stimulus(1'b1, F3_SD, 64'd24, 64'd14);
    check_output("sd_lat", 64'(tr_lat), 64'd2);
    check_output("sd_rd", 64'(tr_rd), 64'd0);
    check_output("sd_wr", 64'(tr_wr), 64'd1);
    apply_stimulus(1'b0, F3_LD, 64'd24, 64'd0);
    check_output("sd_readback", tr_rdata, 64'd14);

    // Errors and range boundary
    apply_stimulus(1'b0, F3_LD, 64'd2041, 64'd0);
    check_output("oor_err", 64'(tr_err), 64'd1);
    check_output("oor_lat", 64'(tr_lat), 64'd1);
    check_output("oor_rd", 64'(tr_rd), 64'd0);
    check_output("oor_rdata", tr_rdata, 64'd14);
    apply_stimulus(1'b0, 3'b111, 64'd32, 64'd0);
    check_output("bad_ld_err", 64'(tr_err), 64'd1);
    check_output("bad_ld_lat", 64'(tr_lat), 64'd1);
    check_output("bad_ld_rdata", tr_rdata, 64'd14);
    apply_stimulus(1'b1, 3'b100, 64'd32, 64'd0);
    check_output("bad_st_err", 64'(tr_err), 64'd1);
    check_output("bad_st_wr", 64'(tr_wr), 64'd0);
    check_output("bad_st_mem", peek_window(32), 64'h8040_2010_0804_BEEF);
    apply_stimulus(1'b0, F3_LD, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0);
    check_output("wrap_err", 64'(tr_err), 64'd1);
    apply_stimulus(1'b0, F3_LD, 64'd2040, 64'd0);
    check_output("edge_err", 64'(tr_err), 64'd0);
    check_output("edge_lat", 64'(tr_lat), 64'd2);
    check_output("edge_data", tr_rdata, 64'hEEEE_EEEE_EEEE_EEEE);

    // Reset during the write phase of a SW
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b1;
    bus.req_funct3 = F3_SW;
    bus.req_addr   = 64'd40;
    bus.req_wdata  = 64'h0BAD_F00D_CAFE_D00D;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check_output("rmw_read_phase", 64'(mem_read), 64'd1);
    @(posedge clk); #1;
    check_output("rmw_write_phase", 64'(mem_write), 64'd1);
    reset_n = 1'b0;
    #1;
    check_output("rmw_write_killed", 64'(mem_write), 64'd0);
    @(posedge clk); #1;
    check_output("rmw_window_kept", peek_window(40), 64'h80C0_A090_1122_3344);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check_output("post_req_ready",  64'(bus.req_ready), 64'd1);
    check_output("post_resp_valid", 64'(bus.resp_valid), 64'd0);
    check_output("post_resp_err",   64'(bus.resp_err), 64'd0);
    check_output("post_resp_rdata", bus.resp_rdata, 64'd0);
    check_output("post_mem_read",   64'(mem_read), 64'd0);
    check_output("post_mem_write",  64'(mem_write), 64'd0);
    check_output("post_mem_addr",   mem_addr, 64'd0);
    check_output("post_mem_wdata",  mem_write_data, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
